// File: rtl/debounce_scheduler.sv
// rtl/debounce_scheduler.sv - shared-timer debouncer with round-robin channel scheduling
//
// Debounces N_INPUTS raw inputs with one shared stable-time counter. A round-robin
// scheduler hands the counter to one changed (pending) input at a time; the input
// commits after DEBOUNCE_CYCLES stable cycles or is dropped if it reverts.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   signal_in      raw asynchronous inputs [N_INPUTS]
//   signal_out     debounced levels [N_INPUTS]
//   pulse_out      one-cycle pulse on a committed 0->1 transition [N_INPUTS]
//   fall_pulse_out one-cycle pulse on a committed 1->0 transition [N_INPUTS]
//                  (present only when DEBOUNCE_SCHED_FALL_PULSE_EN is defined)
//   busy           high while the timer is granted to a channel
//   active_idx     channel holding the timer; last grant while idle
//
// Optional feature macro: DEBOUNCE_SCHED_FALL_PULSE_EN

module debounce_scheduler #(
    parameter int N_INPUTS         = 4,
    parameter int CLK_FREQ_HZ      = 12000000,
    parameter int DEBOUNCE_TIME_MS = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_INPUTS-1:0]         signal_in,
    output logic [N_INPUTS-1:0]         signal_out,
    output logic [N_INPUTS-1:0]         pulse_out,
`ifdef DEBOUNCE_SCHED_FALL_PULSE_EN
    output logic [N_INPUTS-1:0]         fall_pulse_out,
`endif
    output logic                        busy,
    output logic [$clog2(N_INPUTS)-1:0] active_idx
);

    localparam int DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_TIME_MS;
    localparam int TW = $clog2(DEBOUNCE_CYCLES);
    localparam int IW = $clog2(N_INPUTS);
    localparam logic [TW-1:0] TC = TW'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    logic [N_INPUTS-1:0] sync_a;
    logic [N_INPUTS-1:0] sync_b;
    logic [N_INPUTS-1:0] pending;
    logic [0:0]          state;
    logic [TW-1:0]       timer;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       grant;
    logic                grant_valid;

    // A channel needs service whenever its synchronised level differs from its committed level.
    always_comb begin
        pending = sync_b ^ signal_out;
    end

    // Round-robin search starting just after the most recent grant, wrapping modulo N_INPUTS.
    always_comb begin
        int            c;
        logic [IW-1:0] cidx;
        grant       = '0;
        grant_valid = 1'b0;
        c           = 0;
        cidx        = '0;
        for (int k = 1; k <= N_INPUTS; k++) begin
            c = int'(rr_ptr) + k;
            if (c >= N_INPUTS) begin
                c = c - N_INPUTS;
            end
            cidx = IW'(c);
            if (!grant_valid && pending[cidx]) begin
                grant       = cidx;
                grant_valid = 1'b1;
            end
        end
    end

    assign busy = (state == COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a     <= '0;
            sync_b     <= '0;
            signal_out <= '0;
            pulse_out  <= '0;
`ifdef DEBOUNCE_SCHED_FALL_PULSE_EN
            fall_pulse_out <= '0;
`endif
            state      <= IDLE;
            timer      <= '0;
            rr_ptr     <= IW'(N_INPUTS - 1);
            active_idx <= '0;
        end else begin
            sync_a    <= signal_in;
            sync_b    <= sync_a;
            pulse_out <= '0;
`ifdef DEBOUNCE_SCHED_FALL_PULSE_EN
            fall_pulse_out <= '0;
`endif
            if (state == IDLE) begin
                if (grant_valid) begin
                    active_idx <= grant;
                    rr_ptr     <= grant;
                    timer      <= '0;
                    state      <= COUNT;
                end
            end else begin
                if (sync_b[active_idx] == signal_out[active_idx]) begin
                    // Input bounced back to its committed level: release the timer, no output.
                    state <= IDLE;
                end else if (timer == TC) begin
                    signal_out[active_idx] <= sync_b[active_idx];
                    pulse_out[active_idx]  <= sync_b[active_idx];
`ifdef DEBOUNCE_SCHED_FALL_PULSE_EN
                    fall_pulse_out[active_idx] <= ~sync_b[active_idx];
`endif
                    state <= IDLE;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb/tb_debounce_scheduler.sv - randomized self-checking bench for debounce_scheduler

module tb_debounce_scheduler;

    localparam int N  = 4;
    localparam int DC = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] signal_in;
    logic [N-1:0] signal_out;
    logic [N-1:0] pulse_out;
`ifdef DEBOUNCE_SCHED_FALL_PULSE_EN
    logic [N-1:0] fall_pulse_out;
`endif
    logic         busy;
    logic [1:0]   active_idx;

    int n_cmp = 0;
    int n_err = 0;

    debounce_scheduler #(
        .N_INPUTS(N),
        .CLK_FREQ_HZ(1000),
        .DEBOUNCE_TIME_MS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .signal_in(signal_in),
        .signal_out(signal_out),
        .pulse_out(pulse_out),
`ifdef DEBOUNCE_SCHED_FALL_PULSE_EN
        .fall_pulse_out(fall_pulse_out),
`endif
        .busy(busy),
        .active_idx(active_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner/grant-time view of the scheduler.
    logic [N-1:0] m_s1    = '0;
    logic [N-1:0] m_sync  = '0;
    logic [N-1:0] m_out   = '0;
    logic [N-1:0] m_pulse = '0;
    logic [N-1:0] m_fall  = '0;
    int m_owner = -1;
    int m_last  = N - 1;
    int m_shown = 0;
    int m_gcyc  = 0;
    int m_cyc   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_sync = '0; m_out = '0; m_pulse = '0; m_fall = '0;
            m_owner = -1; m_last = N - 1; m_shown = 0; m_gcyc = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            m_pulse = '0;
            m_fall  = '0;
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (m_sync[c] != m_out[c]) begin
                        m_owner = c; m_last = c; m_shown = c; m_gcyc = m_cyc;
                        break;
                    end
                end
            end else if (m_sync[m_owner] == m_out[m_owner]) begin
                m_owner = -1;
            end else if (m_cyc - m_gcyc == DC) begin
                m_out[m_owner] = m_sync[m_owner];
                if (m_sync[m_owner]) m_pulse[m_owner] = 1'b1;
                else                 m_fall[m_owner]  = 1'b1;
                m_owner = -1;
            end
            m_sync = m_s1;
            m_s1   = signal_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("signal_out", 32'(signal_out), 32'(m_out));
        check("pulse_out", 32'(pulse_out), 32'(m_pulse));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("active_idx", 32'(active_idx), 32'(m_shown));
        check("pulse_onehot", 32'($countones(pulse_out) <= 1), 32'd1);
`ifdef DEBOUNCE_SCHED_FALL_PULSE_EN
        check("fall_pulse_out", 32'(fall_pulse_out), 32'(m_fall));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_signal_out", 32'(signal_out), 32'd0);
        check("rst_pulse_out", 32'(pulse_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_active_idx", 32'(active_idx), 32'd0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n, bc, t0, t3, seen_pulse;
        signal_in = '0;
        rst = 1'b0;
        @(negedge clk);
        do_reset();

        // Clean press on channel 2.
        signal_in[2] = 1'b1;
        n = 0; bc = 0;
        while (!signal_out[2] && n < 40) begin
            step(); n++;
            if (busy) bc++;
        end
        check("press_latency", 32'(n - 1), 32'd10);
        check("press_busy_cycles", 32'(bc), 32'd8);
        check("press_pulse", 32'(pulse_out), 32'b0100);
        check("press_idx", 32'(active_idx), 32'd2);
        step();
        check("press_pulse_clear", 32'(pulse_out), 32'd0);

        // Glitch on channel 1: 5 cycles high, then low.
        signal_in[1] = 1'b1;
        settle(5);
        signal_in[1] = 1'b0;
        settle(20);
        check("glitch_out", 32'(signal_out[1]), 32'd0);
        check("glitch_idle", 32'(busy), 32'd0);

        // Contention on channels 0 and 3 from a fresh round-robin pointer.
        signal_in = '0;
        @(negedge clk);
        do_reset();
        signal_in[0] = 1'b1;
        signal_in[3] = 1'b1;
        n = 0; t0 = -1; t3 = -1;
        while (t3 < 0 && n < 60) begin
            step(); n++;
            if (signal_out[0] && t0 < 0) t0 = n;
            if (signal_out[3] && t3 < 0) t3 = n;
        end
        check("contend_order", 32'(t0 >= 0 && t0 < t3), 32'd1);
        check("contend_gap", 32'(t3 - t0), 32'd9);

        // Round-robin fairness: channel 1 toggles slowly while channel 2 rises.
        signal_in = '0;
        settle(60);
        signal_in[1] = 1'b1;
        settle(3);
        signal_in[2] = 1'b1;
        seen_pulse = 0;
        for (int i = 0; i < 66; i++) begin
            if (i % 11 == 10) signal_in[1] = ~signal_in[1];
            step();
            if (pulse_out[2]) seen_pulse = 1;
        end
        check("rr_ch2_served", 32'(seen_pulse), 32'd1);

        // Reset mid-COUNT on channel 0.
        signal_in = '0;
        settle(60);
        signal_in[0] = 1'b1;
        n = 0;
        while (!busy && n < 20) begin step(); n++; end
        check("midcount_grant", 32'(busy), 32'd1);
        settle(4);
        do_reset();
        n = 0;
        while (!signal_out[0] && n < 40) begin step(); n++; end
        check("post_reset_latency", 32'(n - 1), 32'd10);
        check("post_reset_pulse", 32'(pulse_out), 32'b0001);

        // Release of channel 2.
        signal_in[2] = 1'b1;
        settle(25);
        signal_in[2] = 1'b0;
        n = 0; seen_pulse = 0;
        while (signal_out[2] && n < 40) begin
            step(); n++;
            if (pulse_out != 0) seen_pulse = 1;
        end
        check("release_latency", 32'(n - 1), 32'd10);
        check("release_no_pulse", 32'(seen_pulse), 32'd0);
`ifdef DEBOUNCE_SCHED_FALL_PULSE_EN
        check("release_fall_pulse", 32'(fall_pulse_out), 32'b0100);
        step();
        check("release_fall_clear", 32'(fall_pulse_out), 32'd0);
`endif

        // Randomized bouncing inputs with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 24) == 0) signal_in[b] = ~signal_in[b];
            end
            if ($urandom_range(0, 1499) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
